// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide unit.
// Op codes, sequencer states, the iteration count and a conditional negate helper.
package mips_pkg;

  localparam int MD_W    = 32;
  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  // Two's-complement negate when c is set; 0x80000000 maps to itself.
  function automatic logic [MD_W-1:0] neg_if(input logic c, input logic [MD_W-1:0] v);
    return c ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mips_muldiv_ctrl.sv
// Sequencer for the multiply/divide unit: IDLE -> RUN (32 iterations) -> FIX.
// Produces the registered busy/done outputs and datapath step strobes.
module mips_muldiv_ctrl
  import mips_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic idle_o,
  output logic accept_o,
  output logic run_o,
  output logic fix_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CNT_W = $clog2(MD_ITER);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q;

  // State, iteration counter and done pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_q == MD_FIX);
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_RUN;
          cnt_d   = '0;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_RUN: begin
        if (cnt_q == CNT_W'(MD_ITER - 1)) begin
          state_d = MD_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  assign idle_o   = (state_q == MD_IDLE);
  assign accept_o = (state_q == MD_IDLE) && start_i;
  assign run_o    = (state_q == MD_RUN);
  assign fix_o    = (state_q == MD_FIX);
  assign busy_o   = (state_q != MD_IDLE);
  assign done_o   = done_q;

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Magnitudes are processed unsigned; signs are restored in the FIX cycle.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W = WIDTH;

  logic idle_s, accept_s, run_s, fix_s;

  mips_muldiv_ctrl u_ctrl (
    .clk_i   (clk),
    .rst_i   (reset),
    .start_i (start),
    .idle_o  (idle_s),
    .accept_o(accept_s),
    .run_o   (run_s),
    .fix_o   (fix_s),
    .busy_o  (busy),
    .done_o  (done)
  );

  // acc holds {product} for multiply, {remainder, quotient} for divide.
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           div_q, div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic           bzero_q, bzero_d;

  op_e            op_s;
  logic           is_div_s, is_signed_s;
  logic [W-1:0]   a_mag_s, b_mag_s, res_hi_s, res_lo_s;
  logic [W:0]     mul_sum_s, div_diff_s;
  logic [2*W-1:0] prod_s;

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
    end
  end

  // Operand latch, per-iteration step, sign fixup and HI/LO update.
  always_comb begin
    op_s        = op_e'(op);
    is_div_s    = (op_s == OP_DIV) || (op_s == OP_DIVU);
    is_signed_s = (op_s == OP_MULT) || (op_s == OP_DIV);
    a_mag_s     = neg_if(is_signed_s & rs_data[W-1], rs_data);
    b_mag_s     = neg_if(is_signed_s & rt_data[W-1], rt_data);

    mul_sum_s  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    // Remainder is always below the divisor, so bit W of the trial is the borrow.
    div_diff_s = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, opnd_q};
    prod_s     = neg_res_q ? (~acc_q + 64'd1) : acc_q;

    if (div_q) begin
      res_lo_s = bzero_q ? {W{1'b1}} : neg_if(neg_res_q, acc_q[W-1:0]);
      res_hi_s = neg_if(neg_rem_q, acc_q[2*W-1:W]);
    end else begin
      res_lo_s = prod_s[W-1:0];
      res_hi_s = prod_s[2*W-1:W];
    end

    acc_d     = acc_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (accept_s) begin
      div_d     = is_div_s;
      neg_res_d = is_signed_s & (rs_data[W-1] ^ rt_data[W-1]);
      neg_rem_d = is_signed_s & rs_data[W-1];
      bzero_d   = (rt_data == {W{1'b0}});
      acc_d     = {{W{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
      opnd_d    = is_div_s ? b_mag_s : a_mag_s;
    end else if (run_s) begin
      if (div_q) begin
        if (!div_diff_s[W]) begin
          acc_d = {div_diff_s[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[2*W-2:0], 1'b0};
        end
      end else begin
        acc_d = {mul_sum_s, acc_q[W-1:1]};
      end
    end else if (fix_s) begin
      hi_d = res_hi_s;
      lo_d = res_lo_s;
    end else if (idle_s) begin
      hi_d = hi_we ? write_data : hi_q;
      lo_d = lo_we ? write_data : lo_q;
    end else begin
      acc_d = acc_q;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: scoreboard fed at issue time, monitor
// compares on every done pulse; arithmetic reference model built on 64-bit ints.
module tb_mips_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we, busy, done;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, write_data, hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mdl_hi, mdl_lo;

  mips_muldiv dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .write_data(write_data),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic, returns {hi, lo}.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb2, p, q, rm;
    logic [63:0] ua, ub;
    sa  = $signed(a);
    sb2 = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (o)
      2'd0: begin p = sa * sb2; return p; end
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q  = sa / sb2;
        rm = sa % sb2;
        return {rm[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with empty scoreboard at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result_hi", {32'd0, hi}, {32'd0, mon_e.hi});
        check("result_lo", {32'd0, lo}, {32'd0, mon_e.lo});
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  // Called in the low phase; returns #1 after the sampling edge k.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int k);
    exp_t        e;
    logic [63:0] r;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    k      = cyc;
    r      = ref_op(o, a, b);
    e.hi   = r[63:32];
    e.lo   = r[31:0];
    e.cyc  = k + 33;
    sb.push_back(e);
    mdl_hi = r[63:32];
    mdl_lo = r[31:0];
    start  = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_done(input int k);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cyc == k + 32) begin
        check("busy_before_fix", {63'd0, busy}, 64'd1);
        check("done_early", {63'd0, done}, 64'd0);
      end
      if (done) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within 40 cycles of start at cycle %0d", k);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h00000000;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[7] = '{
    '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
    '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
    '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
    '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{2'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E},
    '{2'd2, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF},
    '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000}
  };

  initial begin
    int          k;
    logic [31:0] prev_lo, prev_hi;
    reset = 1'b1; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0; write_data = '0;
    mdl_hi = '0; mdl_lo = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Test-plan vectors against literal expectations as well as the model.
    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].a, vecs[i].b, k);
      wait_done(k);
      check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].ehi});
      check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].elo});
      if (i == 0) begin
        @(negedge clk);
        check("done_single_pulse", {63'd0, done}, 64'd0);
      end
    end

    // MTHI in idle.
    hi_we = 1'b1; write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    hi_we = 1'b0; mdl_hi = 32'hCAFEF00D;
    check("mthi", {32'd0, hi}, {32'd0, mdl_hi});
    check("mthi_lo_kept", {32'd0, lo}, {32'd0, mdl_lo});
    @(negedge clk);

    // MTHI + MTLO together.
    hi_we = 1'b1; lo_we = 1'b1; write_data = 32'h0BADBEEF;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0; mdl_hi = 32'h0BADBEEF; mdl_lo = 32'h0BADBEEF;
    check("mthi_mtlo_both", {hi, lo}, {mdl_hi, mdl_lo});
    @(negedge clk);

    // MTLO while busy is dropped.
    prev_lo = lo;
    issue(2'd1, 32'd12345, 32'd678, k);
    @(negedge clk);
    lo_we = 1'b1; write_data = 32'h5A5A5A5A;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo_busy_ignored", {32'd0, lo}, {32'd0, prev_lo});
    wait_done(k);

    // Second start mid-run is ignored.
    issue(2'd3, 32'd1000000, 32'd37, k);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd0; rs_data = 32'hDEAD0001; rt_data = 32'h00000003;
    @(negedge clk);
    start = 1'b0;
    wait_done(k);
    repeat (3) @(negedge clk);
    check("no_second_op", {63'd0, busy}, 64'd0);

    // start wins over a simultaneous MTHI.
    prev_hi = hi;
    hi_we = 1'b1; write_data = 32'h11112222;
    issue(2'd2, 32'hFFFF0000, 32'd3, k);
    hi_we = 1'b0;
    check("start_beats_mthi", {32'd0, hi}, {32'd0, prev_hi});
    wait_done(k);

    // Asynchronous reset mid-DIVU, then a fresh op.
    issue(2'd3, 32'hABCDEF01, 32'd13, k);
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_done", {63'd0, done}, 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    sb.delete();
    mdl_hi = '0; mdl_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    issue(2'd1, 32'd6, 32'd7, k);
    wait_done(k);
    check("post_reset_mul", {hi, lo}, {32'd0, 32'd42});

    // Randomized traffic checked by the monitor.
    for (int n = 0; n < 40; n++) begin
      issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), k);
      wait_done(k);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
